// File: rtl/core2cpu_pio_in.sv
// core2cpu_pio_in: Avalon-MM input PIO, receiving end of the inter-core link.
// Synchronised live level, sticky edge capture and masked level interrupt.
module core2cpu_pio_in #(
  parameter int WIDTH     = 2,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;
  logic [1:0]       cnt;
  logic             edge_en;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign edge_en      = (cnt == 2'd3);
  assign unused_wdata = ^writedata;

  always_comb begin
    case (EDGE_TYPE)
      1:       det = ~sync2 & prev;
      2:       det = sync2 ^ prev;
      default: det = sync2 & ~prev;
    endcase
  end

  // Guard keeps levels present at reset release from posing as edges.
  assign hit = edge_en ? det : '0;
  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= '0;
      sync2        <= '0;
      prev         <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      cnt          <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
      if (!edge_en)
        cnt <= cnt + 2'd1;
      if (wr && address == 2'd2)
        irq_mask <= writedata[WIDTH-1:0];
      // A new edge beats a same-cycle clear.
      edge_capture <= (edge_capture & ~clr) | hit;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = sync2;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_capture;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_core2cpu_pio_in.sv
// tb_core2cpu_pio_in: scoreboard bench for core2cpu_pio_in.
// Rising, falling and any-edge builds share one bus and one input.
module tb_core2cpu_pio_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [1:0]  in_port = '0;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  always #10 clk = ~clk;

  core2cpu_pio_in #(.WIDTH(2), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  core2cpu_pio_in #(.WIDTH(2), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1)
  );

  core2cpu_pio_in #(.WIDTH(2), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick_rd(input int i);
    return (i == 0) ? rd0 : (i == 1) ? rd1 : rd2;
  endfunction

  function automatic logic [31:0] pick_irq(input int i);
    return {31'd0, (i == 0) ? irq0 : (i == 1) ? irq1 : irq2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string tag, input int i,
                           input logic [1:0] a, input logic [31:0] exp);
    exp_t e;
    address = a;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk(e.tag, pick_rd(i), e.exp);
  endtask

  task automatic expect_irq(input string tag, input int i,
                            input logic exp);
    exp_t e;
    e.tag = tag;
    e.exp = {31'd0, exp};
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk(e.tag, pick_irq(i), e.exp);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    in_port = 2'b11;
    reset_n = 1'b0;
    repeat (3) tick();
    expect_rd("rst_data", 0, 2'd0, 32'h0);
    expect_irq("rst_irq", 0, 1'b0);
    reset_n = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 3; i++) begin
      expect_rd($sformatf("guard_data%0d", i), i, 2'd0, 32'h3);
      expect_rd($sformatf("guard_cap%0d", i), i, 2'd3, 32'h0);
      expect_irq($sformatf("guard_irq%0d", i), i, 1'b0);
    end

    bus_wr(2'd1, 32'hFFFF_FFFF);
    bus_wr(2'd0, 32'h0);
    expect_rd("reserved", 0, 2'd1, 32'h0);
    expect_rd("data_ro", 0, 2'd0, 32'h3);

    in_port = 2'b00;
    repeat (4) tick();
    expect_rd("fall11_rise", 0, 2'd3, 32'h0);
    expect_rd("fall11_fall", 1, 2'd3, 32'h3);
    expect_rd("fall11_any", 2, 2'd3, 32'h3);
    bus_wr(2'd3, 32'h3);
    expect_rd("clr_fall", 1, 2'd3, 32'h0);
    expect_rd("clr_any", 2, 2'd3, 32'h0);
    bus_wr(2'd2, 32'hFFFF_FFFD);
    expect_rd("mask_rd", 0, 2'd2, 32'h1);

    tick();
    in_port = 2'b01;
    tick();
    tick();
    expect_rd("lat_n1_cap", 0, 2'd3, 32'h0);
    expect_irq("lat_n1_irq", 0, 1'b0);
    tick();
    expect_rd("lat_n2_cap", 0, 2'd3, 32'h1);
    expect_irq("lat_n2_irq", 0, 1'b1);
    expect_rd("rise01_fall", 1, 2'd3, 32'h0);
    expect_rd("rise01_any", 2, 2'd3, 32'h1);

    bus_wr(2'd3, 32'h1);
    expect_irq("w1c_irq", 0, 1'b0);
    expect_rd("w1c_cap", 0, 2'd3, 32'h0);

    in_port = 2'b00;
    repeat (4) tick();
    expect_rd("fall01_rise", 0, 2'd3, 32'h0);
    bus_wr(2'd3, 32'h2);
    expect_rd("w0_keep_fall", 1, 2'd3, 32'h1);
    expect_rd("w0_keep_any", 2, 2'd3, 32'h1);
    bus_wr(2'd3, 32'h3);

    in_port = 2'b10;
    repeat (4) tick();
    expect_rd("rise10_rise", 0, 2'd3, 32'h2);
    in_port = 2'b00;
    repeat (4) tick();
    expect_rd("fall10_fall", 1, 2'd3, 32'h2);
    in_port = 2'b10;
    tick();
    tick();
    bus_wr(2'd3, 32'h2);
    expect_rd("setwins_rise", 0, 2'd3, 32'h2);
    expect_rd("clr_nohit_fall", 1, 2'd3, 32'h0);
    expect_rd("setwins_any", 2, 2'd3, 32'h2);

    expect_irq("masked_irq", 0, 1'b0);
    bus_wr(2'd2, 32'h2);
    expect_irq("unmask_irq", 0, 1'b1);
    bus_wr(2'd2, 32'h0);
    expect_irq("remask_irq", 0, 1'b0);
    expect_rd("remask_cap", 0, 2'd3, 32'h2);
    expect_rd("remask_rd", 0, 2'd2, 32'h0);

    in_port = 2'b11;
    tick();
    tick();
    reset_n = 1'b0;
    expect_rd("midrst_cap", 0, 2'd3, 32'h0);
    expect_irq("midrst_irq", 0, 1'b0);
    reset_n = 1'b1;
    expect_rd("rel_data", 0, 2'd0, 32'h0);
    expect_rd("rel_mask", 0, 2'd2, 32'h0);
    expect_rd("rel_cap", 0, 2'd3, 32'h0);
    expect_rd("rel_cap_any", 2, 2'd3, 32'h0);
    repeat (10) tick();
    expect_rd("reguard_rise", 0, 2'd3, 32'h0);
    expect_rd("reguard_any", 2, 2'd3, 32'h0);
    expect_rd("reguard_data", 0, 2'd0, 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core2cpu_pio_in.md
Name: core2cpu_pio_in

Overview:
- Avalon-MM slave input PIO. It is the receiving end of the inter-core parallel link driven by the peer CPU's output PIO.
- Synchronises the peer's `out_port` bits into the local clock domain and exposes their live level to the local CPU.
- Latches selected edges into a sticky edge-capture register.
- Raises a level interrupt when an unmasked captured edge is pending.

Parameters:
- WIDTH, 2, number of input bits; legal range 1..32.
- EDGE_TYPE, 0, edge that sets capture bits: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous input from the peer core's PIO.
- readdata  output  32  read data, zero wait states, combinational from address.
- irq  output  1  level interrupt, active high.

Behaviour:
- Reset (async, reset_n = 0):
  - sync1, sync2, prev, edge_capture, irq_mask, startup counter all cleared to 0.
  - Therefore irq = 0 and readdata reflects zeros for register contents.
- Synchroniser: in_port → sync1 → sync2, two flops per bit, every clk. prev <= sync2 every clk.
- Startup guard:
  - 2-bit counter increments each clk after reset release and saturates at 3.
  - edge_en = (counter == 3).
  - No capture before edge_en, so an input already high at reset release is never reported as an edge.
- Edge detect, combinational, gated by edge_en:
  - rise = sync2 & ~prev.
  - fall = ~sync2 & prev.
  - any = sync2 ^ prev.
  - Selection by EDGE_TYPE.
- Latency: an in_port change meeting setup to clk edge N:
  - appears in sync2 after edge N+1;
  - sets edge_capture after edge N+2;
  - irq high in the same cycle if the bit is masked in.
- Register map (writes when chipselect & ~write_n; reads are side-effect free):
  - 0 data: read {zeros, sync2}; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 irq_mask: RW, writedata[WIDTH-1:0] stored; upper bits read 0.
  - 3 edge_capture: read sticky bits; write-1-to-clear per bit; writing 0 leaves the bit unchanged.
- Simultaneous edge and W1C on the same bit in the same cycle: set wins, bit stays 1. Other bits are cleared normally.
- irq = |(edge_capture & irq_mask), combinational from registers.
  - Unmasking an already-captured bit asserts irq in the cycle after the mask write.
  - Masking deasserts it the cycle after the write; the capture bit is retained.
- Reset mid-operation: all state is cleared immediately and the startup guard restarts.
- readdata upper bits [31:WIDTH] are always 0.
- No read-side clear and no wait states.

Test Plan:
- Reset with in_port = 2'b11 held, release reset, run 10 clk:
  - addr0 reads 0x3;
  - addr3 reads 0x0;
  - irq = 0 (startup guard).
- EDGE_TYPE = 0, mask = 0x1:
  - drive in_port 00→01 before edge N;
  - edge_capture bit0 = 1 and irq = 1 exactly after edge N+2;
  - addr3 reads 0x1.
- Write 0x1 to addr3:
  - irq drops the next cycle; addr3 reads 0x0.
  - Then write 0x2 with bit0 clear: no effect on other bits.
- Same-cycle rising edge on bit1 and W1C of bit1:
  - bit1 remains 1 after the cycle.
- Capture bit1 with mask = 0:
  - irq = 0.
  - Write mask 0x2: irq = 1 the next cycle.
  - Write mask 0x0: irq = 0 and addr3 still reads 0x2.
- EDGE_TYPE = 1 and EDGE_TYPE = 2 builds:
  - 01→00 captures bit0 only for types 1 and 2;
  - 00→01 captures only for type 2.
  - Assert reset_n low mid-pulse: all registers read 0 immediately after release.
